// File: rtl/ppfifo_source.sv
// Write side of the ping-pong FIFO: grabs a free buffer, fills it with a running
// pattern that continues across buffers, then hands it back.
//   state   | meaning
//   IDLE    | waiting for enable and a free buffer
//   WRITE   | owning a buffer, one word per cycle until full or disabled
//   RELEASE | dead cycle so the FIFO can refresh i_wr_rdy
module ppfifo_source #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_enable,
  input  logic [1:0]            i_wr_rdy,
  output logic [1:0]            o_wr_act,
  input  logic [23:0]           i_wr_size,
  output logic                  o_wr_stb,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  output logic                  o_busy,
  output logic [31:0]           o_buf_count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WRITE   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [1:0]            act_q, act_d;
  logic                  busy_q, busy_d;
  logic                  stb_q, stb_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] pattern_q, pattern_d;
  logic [23:0]           count_q, count_d;
  logic [23:0]           size_q, size_d;
  logic [31:0]           buf_count_q, buf_count_d;

  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    busy_d      = busy_q;
    stb_d       = 1'b0;
    data_d      = data_q;
    pattern_d   = pattern_q;
    count_d     = count_q;
    size_d      = size_q;
    buf_count_d = buf_count_q;
    case (state_q)
      IDLE: begin
        if (i_enable && (i_wr_rdy != 2'b00)) begin
          // buffer 0 wins a tie
          act_d   = i_wr_rdy[0] ? 2'b01 : 2'b10;
          busy_d  = 1'b1;
          size_d  = i_wr_size;
          count_d = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (i_enable && (count_q < size_q)) begin
          stb_d     = 1'b1;
          data_d    = pattern_q;
          pattern_d = pattern_q + 1'b1;
          count_d   = count_q + 24'd1;
        end else begin
          act_d       = 2'b00;
          busy_d      = 1'b0;
          buf_count_d = buf_count_q + 32'd1;
          state_d     = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        act_d   = 2'b00;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      act_q       <= 2'b00;
      busy_q      <= 1'b0;
      stb_q       <= 1'b0;
      data_q      <= '0;
      pattern_q   <= '0;
      count_q     <= '0;
      size_q      <= '0;
      buf_count_q <= '0;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      busy_q      <= busy_d;
      stb_q       <= stb_d;
      data_q      <= data_d;
      pattern_q   <= pattern_d;
      count_q     <= count_d;
      size_q      <= size_d;
      buf_count_q <= buf_count_d;
    end
  end

  assign o_wr_act    = act_q;
  assign o_busy      = busy_q;
  assign o_wr_stb    = stb_q;
  assign o_wr_data   = data_q;
  assign o_buf_count = buf_count_q;

endmodule

// File: tb/tb_ppfifo_source.sv
// Directed scenarios followed by random traffic, checked every cycle against a
// buffer-level reference model (owner, words left, dead cycle, running pattern).
module tb_ppfifo_source;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_enable;
  logic [1:0]  i_wr_rdy;
  logic [1:0]  o_wr_act;
  logic [23:0] i_wr_size;
  logic        o_wr_stb;
  logic [7:0]  o_wr_data;
  logic        o_busy;
  logic [31:0] o_buf_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model
  logic [1:0]  m_act;
  int          m_left;
  bit          m_dead;
  logic [7:0]  m_pat;
  logic [7:0]  m_data;
  bit          m_stb;
  logic [31:0] m_bufs;

  logic [7:0] obs[$];
  int         obs_cyc[$];

  ppfifo_source #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_wr_rdy(i_wr_rdy),
    .o_wr_act(o_wr_act), .i_wr_size(i_wr_size), .o_wr_stb(o_wr_stb),
    .o_wr_data(o_wr_data), .o_busy(o_busy), .o_buf_count(o_buf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    m_stb = 1'b0;
    if (!rst_n) begin
      m_act = 2'b00; m_left = 0; m_dead = 0; m_pat = 8'd0; m_data = 8'd0; m_bufs = 32'd0;
    end else if (m_act != 2'b00) begin
      if (i_enable && m_left > 0) begin
        m_stb = 1'b1; m_data = m_pat; m_pat = m_pat + 8'd1; m_left--;
      end else begin
        m_act = 2'b00; m_bufs = m_bufs + 32'd1; m_dead = 1;
      end
    end else if (m_dead) begin
      m_dead = 0;
    end else if (i_enable && i_wr_rdy != 2'b00) begin
      m_act  = i_wr_rdy[0] ? 2'b01 : 2'b10;
      m_left = int'(i_wr_size);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    chk("act", {30'd0, o_wr_act}, {30'd0, m_act});
    chk("stb", {31'd0, o_wr_stb}, {31'd0, m_stb});
    chk("data", {24'd0, o_wr_data}, {24'd0, m_data});
    chk("busy", {31'd0, o_busy}, {31'd0, (m_act != 2'b00)});
    chk("buf_count", o_buf_count, m_bufs);
    if (o_wr_act == 2'b11) chk("act_onehot", {30'd0, o_wr_act}, 32'd1);
    if (o_wr_stb) begin obs.push_back(o_wr_data); obs_cyc.push_back(cyc); end
  endtask

  task automatic chk_obs(input string tag, input int first, input int n);
    chk({tag, "_nwords"}, obs.size(), n);
    for (int k = 0; k < n && k < obs.size(); k++)
      chk({tag, "_word"}, {24'd0, obs[k]}, (first + k) % 256);
  endtask

  initial begin
    rst_n = 1'b0; i_enable = 1'b1; i_wr_rdy = 2'b11; i_wr_size = 24'd4;
    m_act = 0; m_left = 0; m_dead = 0; m_pat = 0; m_data = 0; m_stb = 0; m_bufs = 0;

    // reset held with enable and both buffers free
    repeat (3) step();
    chk("reset_act", {30'd0, o_wr_act}, 32'd0);
    chk("reset_count", o_buf_count, 32'd0);
    rst_n = 1'b1; i_wr_rdy = 2'b00;
    step();

    // single buffer of 4
    obs.delete(); obs_cyc.delete();
    i_wr_rdy = 2'b01; i_wr_size = 24'd4;
    step();
    chk("single_grant", {30'd0, o_wr_act}, 32'd1);
    i_wr_rdy = 2'b00;
    repeat (4) step();
    step();
    chk("single_drop", {30'd0, o_wr_act}, 32'd0);
    chk("single_bufs", o_buf_count, 32'd1);
    chk_obs("single", 0, 4);
    step();

    // ping-pong, size 3
    obs.delete(); obs_cyc.delete();
    i_wr_rdy = 2'b11; i_wr_size = 24'd3;
    step();
    chk("pp_grant0", {30'd0, o_wr_act}, 32'd1);
    repeat (4) step();
    i_wr_rdy = 2'b10;
    step();
    step();
    chk("pp_grant1", {30'd0, o_wr_act}, 32'd2);
    repeat (4) step();
    i_wr_rdy = 2'b00;
    step();
    chk("pp_bufs", o_buf_count, 32'd3);
    chk_obs("pp", 4, 6);
    if (obs_cyc.size() == 6) chk("pp_gap_ok", {31'd0, (obs_cyc[3] - obs_cyc[2] >= 3)}, 32'd1);

    // wrap: preload 244 words (pattern now 10), then 254,255,0,1
    i_wr_rdy = 2'b01; i_wr_size = 24'd244;
    step(); i_wr_rdy = 2'b00;
    repeat (246) step();
    obs.delete(); obs_cyc.delete();
    i_wr_rdy = 2'b01; i_wr_size = 24'd4;
    step(); i_wr_rdy = 2'b00;
    i_wr_size = 24'd9;
    repeat (6) step();
    chk_obs("wrap", 254, 4);

    // early stop after 3rd strobe of 10
    rst_n = 1'b0; step(); rst_n = 1'b1;
    obs.delete(); obs_cyc.delete();
    i_wr_rdy = 2'b01; i_wr_size = 24'd10;
    step(); i_wr_rdy = 2'b00;
    repeat (3) step();
    i_enable = 1'b0;
    step();
    chk("early_drop", {30'd0, o_wr_act}, 32'd0);
    chk("early_stb", {31'd0, o_wr_stb}, 32'd0);
    i_wr_rdy = 2'b11;
    repeat (5) step();
    chk("early_nogrant", {30'd0, o_wr_act}, 32'd0);
    chk("early_bufs", o_buf_count, 32'd1);
    chk_obs("early", 0, 3);

    // size 0, then reset mid-buffer
    rst_n = 1'b0; step(); rst_n = 1'b1;
    obs.delete(); obs_cyc.delete();
    i_enable = 1'b1; i_wr_rdy = 2'b01; i_wr_size = 24'd0;
    step();
    chk("size0_grant", {30'd0, o_wr_act}, 32'd1);
    i_wr_rdy = 2'b00;
    step();
    chk("size0_release", {30'd0, o_wr_act}, 32'd0);
    step();
    chk("size0_bufs", o_buf_count, 32'd1);
    chk("size0_nostb", obs.size(), 32'd0);
    i_wr_rdy = 2'b01; i_wr_size = 24'd8;
    step(); i_wr_rdy = 2'b00;
    repeat (2) step();
    rst_n = 1'b0;
    step();
    chk("midrst_act", {30'd0, o_wr_act}, 32'd0);
    chk("midrst_stb", {31'd0, o_wr_stb}, 32'd0);
    chk("midrst_bufs", o_buf_count, 32'd0);
    rst_n = 1'b1;
    chk_obs("midrst", 0, 2);

    // random traffic
    for (int t = 0; t < 2000; t++) begin
      i_enable  = ($urandom_range(0, 7) != 0);
      i_wr_rdy  = 2'($urandom_range(0, 3));
      i_wr_size = 24'($urandom_range(0, 6));
      rst_n     = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
